// File: rtl/lut_cfg_ctrl.sv
// lut_cfg_ctrl: configuration and access controller for a bank of 2-input LUT cells.
//
// A host loads a cell's 4-bit truth table through the cfg port; the table is shifted
// bit-serially (LSB first) into a staging register and then committed to the cell.
// While no load is in progress, the eval port reads any cell with one-cycle latency.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cfg_valid/cfg_ready         config handshake; cfg_idx selects the cell, cfg_tt the table
//   cfg_done                    one-cycle pulse while the table is being committed
//   eval_valid/eval_ready       evaluate handshake; eval_idx, eval_a, eval_b
//   res_valid, res_out, res_err registered result; res_err flags an unloaded/absent cell
//   busy                        load in progress
//   lut_loaded                  bitmap of cells holding a committed table
module lut_cfg_ctrl #(
    parameter int unsigned NUM_LUTS = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_LUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [3:0]          cfg_tt,
    output logic                cfg_done,
    input  logic                eval_valid,
    output logic                eval_ready,
    input  logic [IDX_W-1:0]    eval_idx,
    input  logic                eval_a,
    input  logic                eval_b,
    output logic                res_valid,
    output logic                res_out,
    output logic                res_err,
    output logic                busy,
    output logic [NUM_LUTS-1:0] lut_loaded
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       tt_q;
    logic [3:0]       staging_q;
    logic [1:0]       cnt_q;
    logic [3:0]       lut_tt_q [NUM_LUTS];

    logic [3:0] eval_tt;
    logic       eval_loaded;

    assign cfg_ready  = (state_q == StIdle);
    assign eval_ready = (state_q == StIdle);
    assign busy       = (state_q != StIdle);

    // Decode by comparison so an index beyond the bank selects nothing.
    always_comb begin
        eval_tt     = '0;
        eval_loaded = 1'b0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (eval_idx == IDX_W'(i)) begin
                eval_tt     = lut_tt_q[i];
                eval_loaded = lut_loaded[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            tt_q       <= '0;
            staging_q  <= '0;
            cnt_q      <= '0;
            lut_loaded <= '0;
            cfg_done   <= 1'b0;
            res_valid  <= 1'b0;
            res_out    <= 1'b0;
            res_err    <= 1'b0;
            for (int i = 0; i < NUM_LUTS; i++) begin
                lut_tt_q[i] <= '0;
            end
        end else begin
            cfg_done  <= 1'b0;
            res_valid <= 1'b0;

            // Evaluation reads the committed table, so a load accepted on the same
            // edge does not affect this result.
            if (eval_valid && eval_ready) begin
                res_valid <= 1'b1;
                res_err   <= ~eval_loaded;
                res_out   <= eval_loaded & eval_tt[{eval_b, eval_a}];
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) begin
                        idx_q     <= cfg_idx;
                        tt_q      <= cfg_tt;
                        staging_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    staging_q <= {tt_q[cnt_q], staging_q[3:1]};
                    cnt_q     <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q  <= StCommit;
                        cfg_done <= 1'b1;  // visible for the whole commit cycle
                    end
                end
                StCommit: begin
                    // An out-of-range index matches no cell and is dropped.
                    for (int i = 0; i < NUM_LUTS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            lut_tt_q[i]   <= staging_q;
                            lut_loaded[i] <= 1'b1;
                        end
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
module tb_lut_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid, cfg_ready, cfg_done;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_tt;
    logic       eval_valid, eval_ready, eval_a, eval_b;
    logic [1:0] eval_idx;
    logic       res_valid, res_out, res_err, busy;
    logic [3:0] lut_loaded;

    int tests = 0;
    int fails = 0;

    // Expected {res_out, res_err} per accepted evaluate, oldest first.
    logic [1:0] exp_q [$];

    lut_cfg_ctrl #(.NUM_LUTS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_tt     (cfg_tt),
        .cfg_done   (cfg_done),
        .eval_valid (eval_valid),
        .eval_ready (eval_ready),
        .eval_idx   (eval_idx),
        .eval_a     (eval_a),
        .eval_b     (eval_b),
        .res_valid  (res_valid),
        .res_out    (res_out),
        .res_err    (res_err),
        .busy       (busy),
        .lut_loaded (lut_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL res_unexpected: got out=%0b err=%0b expected none at %0t",
                         res_out, res_err, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if ({res_out, res_err} !== e) begin
                    fails++;
                    $display("FAIL res: got out=%0b err=%0b expected out=%0b err=%0b at %0t",
                             res_out, res_err, e[1], e[0], $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_eval(input logic [1:0] idx, input logic a, input logic b,
                           input logic exp_out, input logic exp_err);
        check("eval_ready", eval_ready, 1);
        eval_valid = 1'b1;
        eval_idx   = idx;
        eval_a     = a;
        eval_b     = b;
        exp_q.push_back({exp_out, exp_err});
        tick();
        eval_valid = 1'b0;
    endtask

    // Issue a load (optionally with a same-cycle evaluate) and check the full
    // N+1..N+6 handshake timing.
    task automatic do_cfg(input logic [1:0] idx, input logic [3:0] tt, input logic with_eval,
                          input logic [1:0] e_idx, input logic a, input logic b,
                          input logic exp_out, input logic exp_err);
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_idx   = idx;
        cfg_tt    = tt;
        if (with_eval) begin
            eval_valid = 1'b1;
            eval_idx   = e_idx;
            eval_a     = a;
            eval_b     = b;
            exp_q.push_back({exp_out, exp_err});
        end
        tick();
        cfg_valid  = 1'b0;
        eval_valid = 1'b0;
        cfg_tt     = ~tt;  // must be ignored after the handshake
        cfg_idx    = ~idx;
        for (int k = 1; k <= 6; k++) begin
            if (k < 6) begin
                check("cfg_ready_busy", cfg_ready, 0);
                check("eval_ready_busy", eval_ready, 0);
                check("busy", busy, 1);
                check("cfg_done_timing", cfg_done, (k == 5));
                tick();
            end else begin
                check("cfg_ready_after", cfg_ready, 1);
                check("cfg_done_after", cfg_done, 0);
                check("busy_after", busy, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_idx = '0; cfg_tt = '0;
        eval_valid = 1'b0; eval_idx = '0; eval_a = 1'b0; eval_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and unloaded-cell evaluate.
        check("rst_lut_loaded", lut_loaded, 4'b0000);
        check("rst_res_valid", res_valid, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_busy", busy, 0);
        do_eval(2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // NAND into cell 2, then all four input combinations back-to-back.
        do_cfg(2'd2, 4'b0111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lut_loaded_nand", lut_loaded, 4'b0100);
        do_eval(2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        do_eval(2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        do_eval(2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        do_eval(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // AND into cell 1 with a same-cycle evaluate of cell 1 (sees the old state).
        do_cfg(2'd1, 4'b1000, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("lut_loaded_and", lut_loaded, 4'b0110);
        do_eval(2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        do_eval(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a load of cell 3.
        check("cfg_ready_pre_abort", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_tt = 4'b0110;
        tick();                                   // accepted at edge N
        cfg_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            check("abort_cfg_done", cfg_done, 0);
            tick();
        end
        rst_n = 1'b0;                             // sampled at edge N+3
        tick();
        rst_n = 1'b1;
        for (int k = 4; k <= 8; k++) begin
            check("abort_no_done", cfg_done, 0);
            check("abort_idle", busy, 0);
            tick();
        end
        check("abort_lut_loaded", lut_loaded, 4'b0000);
        do_eval(2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        do_eval(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);    // earlier load cleared by reset
        tick();

        // Reload cell 0.
        do_cfg(2'd0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_eval(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_cfg(2'd0, 4'b1110, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_eval(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_eval(2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("lut_loaded_reload", lut_loaded, 4'b0001);
        tick();

        // Hold both valids through a load; a second load follows at N+6.
        check("hold_cfg_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_tt = 4'b1001;
        eval_valid = 1'b1; eval_idx = 2'd0; eval_a = 1'b1; eval_b = 1'b0;
        exp_q.push_back(2'b10);                   // cell 0 = 1110, {b,a}=01 -> 1
        tick();                                   // edge N
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                cfg_idx = 2'd1; cfg_tt = 4'b0000; // ignored while busy
            end
            if (k >= 2 && k <= 5) check("hold_no_res", res_valid, 0);
            if (k <= 5) check("hold_done1", cfg_done, (k == 5));
            if (k == 6) begin
                check("hold_ready_n6", cfg_ready, 1);
                cfg_idx = 2'd3; cfg_tt = 4'b0110;
                eval_idx = 2'd3; eval_a = 1'b1; eval_b = 1'b1;
                exp_q.push_back(2'b10);           // first load 1001, {b,a}=11 -> 1
            end
            if (k == 7) begin
                cfg_valid = 1'b0;
                eval_valid = 1'b0;
                check("hold_busy2", busy, 1);
            end
            if (k >= 8 && k <= 11) check("hold_no_res2", res_valid, 0);
            if (k >= 7 && k <= 11) check("hold_done2", cfg_done, (k == 11));
            if (k == 12) check("hold_idle_end", cfg_ready, 1);
            if (k < 12) tick();
        end
        check("lut_loaded_final", lut_loaded, 4'b1001);
        do_eval(2'd3, 1'b1, 1'b0, 1'b1, 1'b0);    // 0110, {b,a}=01 -> 1
        do_eval(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("pending_results", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
